// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD adder datapath and its digit-serial sequencer.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_adder.sv
// Combinational single-digit BCD adder: X + Y + c_in as a two-digit BCD result.
module bcd_adder
  import bcd_pkg::*;
(
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       c_in,
  output logic       c_out,
  output logic [7:0] result,
  output logic       out_of_range
);

  logic [4:0] raw;
  logic [3:0] ones;

  always_comb begin
    raw          = {1'b0, X} + {1'b0, Y} + {4'b0, c_in};
    out_of_range = (X > BCD_MAX_DIGIT) || (Y > BCD_MAX_DIGIT);
    c_out        = (raw > {1'b0, BCD_MAX_DIGIT});
    // invalid digits can push raw past 19; the ones digit is then meaningless
    ones         = c_out ? 4'(raw - 5'd10) : raw[3:0];
    result       = {3'b000, c_out, ones};
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial packed-BCD adder: one digit per clock through a single bcd_adder.
// Optional BCD_SEQ_EARLY_ABORT_EN: stop at the first out-of-range digit.
module bcd_seq_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  error
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                state, state_nxt;
  logic [4*DIGITS-1:0]   a_reg, b_reg;
  logic                  carry_reg;
  logic [IDX_W-1:0]      idx;

  logic [3:0]            x_dig, y_dig;
  logic                  st_cout, st_oor;
  logic [7:0]            st_result;
  logic                  unused_tens;

  always_comb begin
    x_dig = a_reg[BCD_DIGIT_W*int'(idx) +: BCD_DIGIT_W];
    y_dig = b_reg[BCD_DIGIT_W*int'(idx) +: BCD_DIGIT_W];
  end

  bcd_adder u_stage (
    .X            (x_dig),
    .Y            (y_dig),
    .c_in         (carry_reg),
    .c_out        (st_cout),
    .result       (st_result),
    .out_of_range (st_oor)
  );

  // carry is taken from c_out; the tens digit is redundant
  assign unused_tens = ^st_result[7:4];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ADD;
      ST_ADD: begin
        if (idx == LAST_IDX) state_nxt = ST_DONE;
`ifdef BCD_SEQ_EARLY_ABORT_EN
        if (st_oor) state_nxt = ST_DONE;
`endif
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_ADD);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            error     <= 1'b0;
          end
        end
        ST_ADD: begin
          sum[BCD_DIGIT_W*int'(idx) +: BCD_DIGIT_W] <= st_result[3:0];
          carry_reg <= st_cout;
          error     <= error | st_oor;
          idx       <= idx + IDX_W'(1);
`ifdef BCD_SEQ_EARLY_ABORT_EN
          if ((idx == LAST_IDX) && !st_oor) carry_out <= st_cout;
`else
          if (idx == LAST_IDX) carry_out <= st_cout;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
